// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage register: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush into bubbles, and a saturating downstream-stall counter.
module pipe_stage_buf #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 128,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Handshake: an entry moves on a port only in a cycle where valid and ready are
    // both high at the rising edge; valid never waits on ready, and in_ready is a pure
    // function of the state register, so out_ready has no combinational path upstream.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;
    logic w_clear_skid;

    assign out_valid  = (r_state != ST_EMPTY);
    assign in_ready   = (r_state != ST_TWO);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    assign out_ctrl   = r_main_ctrl;
    assign out_data   = r_main_data;
    assign occupancy  = r_state;
    assign stall_cnt  = r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_clear_skid     = 1'b0;
        if (flush) begin
            // Anything accepted this cycle is squashed along with the held entries.
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    case ({w_in_fire, w_out_fire})
                        2'b11: begin
                            w_load_main_in = 1'b1;
                        end
                        2'b10: begin
                            w_state_nxt = ST_TWO;
                            w_load_skid = 1'b1;
                        end
                        2'b01: begin
                            w_state_nxt = ST_EMPTY;
                        end
                        default: begin
                            w_state_nxt = ST_ONE;
                        end
                    endcase
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main_skid = 1'b1;
                        w_clear_skid     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
            if (CLEAR_DATA) begin
                r_main_data <= '0;
                r_skid_data <= '0;
            end
        end else begin
            if (w_load_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end else if (w_clear_skid) begin
                r_skid_ctrl <= '0;
                r_skid_data <= '0;
            end
        end
    end

    // Counts flush cycles too; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: streaming, backpressure, flush (both data modes),
// counter saturation and asynchronous reset mid-transfer.
module tb_pipe_stage_buf;

    logic        clk;
    logic        reset;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_in_ctrl, a_out_ctrl;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_stall;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_ctrl, b_out_ctrl;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic [3:0]  b_stall;

    int n_total;
    int n_bad;
    logic [31:0] exp_q[$];

    pipe_stage_buf #(.CTRL_W(8), .DATA_W(32), .CLEAR_DATA(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_buf #(.CTRL_W(8), .DATA_W(32), .CLEAR_DATA(1'b0), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cnt(b_stall)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [7:0] c, input logic [31:0] d,
                           input logic rdy, input logic fl);
        a_in_valid  = v;
        a_in_ctrl   = c;
        a_in_data   = d;
        a_out_ready = rdy;
        a_flush     = fl;
    endtask

    task automatic drive_b(input logic v, input logic [7:0] c, input logic [31:0] d,
                           input logic rdy, input logic fl);
        b_in_valid  = v;
        b_in_ctrl   = c;
        b_in_data   = d;
        b_out_ready = rdy;
        b_flush     = fl;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        drive_a(1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
        drive_b(1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();

        check("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, a_in_ready},  32'd1);
        check("rst_occ",       {30'b0, a_occ},       32'd0);
        check("rst_out_ctrl",  {24'b0, a_out_ctrl},  32'd0);
        check("rst_out_data",  a_out_data,           32'd0);
        check("rst_stall",     {16'b0, a_stall},     32'd0);

        // Stream ctrl 1..8 with out_ready held high: one entry per cycle, one cycle later.
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(32'(i));
            drive_a(1'b1, 8'(i), 32'h100 * i, 1'b1, 1'b0);
            step();
            check("stream_valid", {31'b0, a_out_valid}, 32'd1);
            check("stream_ctrl",  {24'b0, a_out_ctrl},  exp_q.pop_front());
            check("stream_data",  a_out_data,           32'h100 * i);
            check("stream_occ",   {30'b0, a_occ},       32'd1);
        end
        drive_a(1'b0, 8'h0, 32'h0, 1'b1, 1'b0);
        step();
        check("stream_drain_occ", {30'b0, a_occ},   32'd0);
        check("stream_stall",     {16'b0, a_stall}, 32'd0);

        // Backpressure: A then B with out_ready low fills both entries.
        drive_a(1'b1, 8'h11, 32'hA11, 1'b0, 1'b0);
        step();
        check("bp_one_occ",  {30'b0, a_occ},      32'd1);
        check("bp_one_ctrl", {24'b0, a_out_ctrl}, 32'h11);
        drive_a(1'b1, 8'h22, 32'hB22, 1'b0, 1'b0);
        step();
        check("bp_two_occ",      {30'b0, a_occ},      32'd2);
        check("bp_two_in_ready", {31'b0, a_in_ready}, 32'd0);
        check("bp_two_stall",    {16'b0, a_stall},    32'd1);
        drive_a(1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
        step();
        check("bp_hold_ctrl",  {24'b0, a_out_ctrl}, 32'h11);
        check("bp_hold_data",  a_out_data,          32'hA11);
        check("bp_hold_stall", {16'b0, a_stall},    32'd2);
        drive_a(1'b0, 8'h0, 32'h0, 1'b1, 1'b0);
        step();
        check("bp_drain1_ctrl", {24'b0, a_out_ctrl}, 32'h22);
        check("bp_drain1_data", a_out_data,          32'hB22);
        check("bp_drain1_occ",  {30'b0, a_occ},      32'd1);
        check("bp_drain1_rdy",  {31'b0, a_in_ready}, 32'd1);
        step();
        check("bp_drain2_occ",   {30'b0, a_occ},   32'd0);
        check("bp_drain2_stall", {16'b0, a_stall}, 32'd2);

        // Flush in TWO with a concurrent offer of 0x33.
        drive_a(1'b1, 8'h44, 32'hC44, 1'b0, 1'b0);
        step();
        drive_a(1'b1, 8'h55, 32'hD55, 1'b0, 1'b0);
        step();
        check("fl2_pre_occ", {30'b0, a_occ}, 32'd2);
        drive_a(1'b1, 8'h33, 32'hE33, 1'b0, 1'b1);
        step();
        check("fl2_valid",    {31'b0, a_out_valid}, 32'd0);
        check("fl2_ctrl",     {24'b0, a_out_ctrl},  32'd0);
        check("fl2_data",     a_out_data,           32'd0);
        check("fl2_occ",      {30'b0, a_occ},       32'd0);
        check("fl2_in_ready", {31'b0, a_in_ready},  32'd1);
        check("fl2_stall",    {16'b0, a_stall},     32'd4);
        drive_a(1'b0, 8'h0, 32'h0, 1'b1, 1'b0);
        step();
        check("fl2_no_33", {31'b0, a_out_valid}, 32'd0);

        // Flush in ONE while an entry is really accepted: that entry is discarded.
        drive_a(1'b1, 8'h66, 32'hF66, 1'b0, 1'b0);
        step();
        drive_a(1'b1, 8'h77, 32'hF77, 1'b0, 1'b1);
        step();
        check("fl1_valid", {31'b0, a_out_valid}, 32'd0);
        drive_a(1'b0, 8'h0, 32'h0, 1'b1, 1'b0);
        step();
        check("fl1_no_77", {31'b0, a_out_valid}, 32'd0);
        check("fl1_occ",   {30'b0, a_occ},       32'd0);

        // CLEAR_DATA=0: flush zeroes ctrl and valid but keeps data.
        drive_b(1'b1, 8'h5A, 32'h1234, 1'b0, 1'b0);
        step();
        check("b_load_data", b_out_data, 32'h1234);
        drive_b(1'b0, 8'h0, 32'h0, 1'b0, 1'b1);
        step();
        check("b_fl_valid", {31'b0, b_out_valid}, 32'd0);
        check("b_fl_ctrl",  {24'b0, b_out_ctrl},  32'd0);
        check("b_fl_data",  b_out_data,           32'h1234);
        check("b_fl_stall", {28'b0, b_stall},     32'd1);

        // CNT_W=4 saturation: 1 already counted, then 20 stalled cycles.
        drive_b(1'b1, 8'h3C, 32'h3C3C, 1'b0, 1'b0);
        step();
        drive_b(1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
        repeat (5) step();
        check("b_stall_6", {28'b0, b_stall}, 32'd6);
        repeat (15) step();
        check("b_stall_sat", {28'b0, b_stall}, 32'd15);
        repeat (3) step();
        check("b_stall_hold", {28'b0, b_stall}, 32'd15);
        check("b_hold_ctrl",  {24'b0, b_out_ctrl}, 32'h3C);

        // Async reset mid-cycle at occupancy 2.
        drive_a(1'b1, 8'h81, 32'h8181, 1'b0, 1'b0);
        step();
        drive_a(1'b1, 8'h82, 32'h8282, 1'b0, 1'b0);
        step();
        check("ar_pre_occ", {30'b0, a_occ}, 32'd2);
        drive_a(1'b0, 8'h0, 32'h0, 1'b0, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        check("ar_valid",    {31'b0, a_out_valid}, 32'd0);
        check("ar_ctrl",     {24'b0, a_out_ctrl},  32'd0);
        check("ar_data",     a_out_data,           32'd0);
        check("ar_occ",      {30'b0, a_occ},       32'd0);
        check("ar_in_ready", {31'b0, a_in_ready},  32'd1);
        check("ar_stall",    {16'b0, a_stall},     32'd0);
        check("ar_b_stall",  {28'b0, b_stall},     32'd0);
        #2;
        reset = 1'b1;
        step();
        check("ar_post_ready", {31'b0, a_in_ready}, 32'd1);
        check("ar_post_occ",   {30'b0, a_occ},      32'd0);
        drive_a(1'b1, 8'h90, 32'h9090, 1'b1, 1'b0);
        step();
        check("ar_post_load", {24'b0, a_out_ctrl}, 32'h90);
        check("ar_post_occ1", {30'b0, a_occ},      32'd1);
        drive_a(1'b0, 8'h0, 32'h0, 1'b1, 1'b0);
        step();
        check("ar_post_drain", {30'b0, a_occ}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
